// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for dcache_controller.
// master = CPU/memory environment, slave = the cache controller.
interface dcache_controller_if #(
  parameter int BLOCK_BYTES = 4
);
  localparam int LINE_W     = 8 * BLOCK_BYTES;
  localparam int MEM_ADDR_W = 8 - $clog2(BLOCK_BYTES);

  logic                  read;
  logic                  write;
  logic [7:0]            address;
  logic [7:0]            writedata;
  logic [7:0]            readdata;
  logic                  busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0]     mem_writedata;
  logic [LINE_W-1:0]     mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache with IDLE/WRITEBACK/FETCH control FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int TAG_W  = 8 - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t                  state_reg;
  logic [NUM_BLOCKS-1:0]   valid_reg;
  logic [NUM_BLOCKS-1:0]   dirty_reg;
  logic [TAG_W-1:0]        tag_arr  [NUM_BLOCKS];
  logic [LINE_W-1:0]       line_arr [NUM_BLOCKS];
  logic [TAG_W-1:0]        miss_tag_reg;
  logic [IDX_W-1:0]        miss_idx_reg;
  logic                    mem_read_reg;
  logic                    mem_write_reg;
  logic [TAG_W+IDX_W-1:0]  mem_address_reg;
  logic [LINE_W-1:0]       mem_writedata_reg;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic              access;
  logic              hit;
  logic              write_hit;
  logic              miss_start;
  logic              victim_dirty;
  logic              fetch_done;
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] merged_line;
  logic [7:0]        line_bytes [BLOCK_BYTES];

  assign tag    = bus.address[7 -: TAG_W];
  assign idx    = bus.address[OFF_W +: IDX_W];
  assign off    = bus.address[OFF_W-1:0];
  assign access = bus.read | bus.write;

  assign cur_line     = line_arr[idx];
  assign hit          = valid_reg[idx] && (tag_arr[idx] == tag);
  assign write_hit    = (state_reg == IDLE) && bus.write && hit;
  assign miss_start   = (state_reg == IDLE) && access && !hit;
  assign victim_dirty = valid_reg[idx] && dirty_reg[idx];
  assign fetch_done   = (state_reg == FETCH) && !bus.mem_busywait;

  // Byte lanes of the indexed line: read mux source and write-merge target.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
      assign line_bytes[gi] = cur_line[gi*8 +: 8];
      assign merged_line[gi*8 +: 8] = (int'(off) == gi) ? bus.writedata
                                                        : cur_line[gi*8 +: 8];
    end
  endgenerate

  assign bus.readdata      = hit ? line_bytes[off] : 8'h00;
  assign bus.busywait      = access && !((state_reg == IDLE) && hit);
  assign bus.mem_read      = mem_read_reg;
  assign bus.mem_write     = mem_write_reg;
  assign bus.mem_address   = mem_address_reg;
  assign bus.mem_writedata = mem_writedata_reg;

  // Tag/data storage is never cleared; only valid bits qualify it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (write_hit) begin
        line_arr[idx] <= merged_line;
      end
      if (fetch_done) begin
        line_arr[miss_idx_reg] <= bus.mem_readdata;
        tag_arr[miss_idx_reg]  <= miss_tag_reg;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg         <= IDLE;
      valid_reg         <= '0;
      dirty_reg         <= '0;
      miss_tag_reg      <= '0;
      miss_idx_reg      <= '0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (write_hit) begin
            dirty_reg[idx] <= 1'b1;
          end else if (miss_start) begin
            // Latch the miss target so a dropped request still installs correctly.
            miss_tag_reg <= tag;
            miss_idx_reg <= idx;
            if (victim_dirty) begin
              state_reg         <= WRITEBACK;
              mem_write_reg     <= 1'b1;
              mem_address_reg   <= {tag_arr[idx], idx};
              mem_writedata_reg <= cur_line;
            end else begin
              state_reg       <= FETCH;
              mem_read_reg    <= 1'b1;
              mem_address_reg <= {tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (!bus.mem_busywait) begin
            state_reg       <= FETCH;
            mem_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b1;
            mem_address_reg <= {miss_tag_reg, miss_idx_reg};
          end
        end
        FETCH: begin
          if (!bus.mem_busywait) begin
            state_reg               <= IDLE;
            mem_read_reg            <= 1'b0;
            valid_reg[miss_idx_reg] <= 1'b1;
            dirty_reg[miss_idx_reg] <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        missed_reg;
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  // An access is classified at its completing (busywait-low) cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      missed_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (access && hit) begin
        missed_reg <= 1'b0;
        if (missed_reg) begin
          if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
        end else begin
          if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
        end
      end else begin
        missed_reg <= access;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a fixed-latency memory model.
module tb_dcache_controller;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dcache_controller_if bus ();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_controller dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Memory model: LAT cycles per transfer, busywait low on the last one.
  logic [31:0] mem_data [64];
  logic [63:0] mem_written = '0;
  int          mcnt = 0;

  function automatic logic [31:0] mem_init(input logic [5:0] a);
    case (a)
      6'h05:   return 32'hDDCCBBAA;
      6'h0D:   return 32'h44332211;
      6'h3F:   return 32'h88776655;
      default: return {26'h0, a};
    endcase
  endfunction

  assign bus.mem_busywait = !((bus.mem_read || bus.mem_write) && mcnt == LAT - 1);
  assign bus.mem_readdata = mem_written[bus.mem_address] ? mem_data[bus.mem_address]
                                                         : mem_init(bus.mem_address);

  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (mcnt == LAT - 1) begin
        mcnt <= 0;
        if (bus.mem_write) begin
          mem_data[bus.mem_address]    <= bus.mem_writedata;
          mem_written[bus.mem_address] <= 1'b1;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Bus monitor: running totals and last observed transfer fields.
  int          wb_total = 0;
  int          fe_total = 0;
  logic [5:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [5:0]  fe_addr = '0;

  always @(negedge clk) begin
    if (bus.mem_write) begin
      wb_total = wb_total + 1;
      wb_addr  = bus.mem_address;
      wb_data  = bus.mem_writedata;
    end
    if (bus.mem_read) begin
      fe_total = fe_total + 1;
      fe_addr  = bus.mem_address;
    end
  end

  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd, output logic [7:0] rdat,
                            output int stalls);
    @(negedge clk);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = wd;
    stalls        = 0;
    #1;
    while (bus.busywait && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdat = bus.readdata;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.busywait !== 1'b0) begin
      miscompares++; $display("FAIL reset_busywait got %b expected 0", bus.busywait);
    end
    vectors++;
    if (bus.readdata !== 8'h00) begin
      miscompares++; $display("FAIL reset_readdata got %h expected 00", bus.readdata);
    end
    vectors++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      miscompares++; $display("FAIL reset_strobes got %b expected 00", {bus.mem_read, bus.mem_write});
    end
`ifdef DCACHE_STATS_EN
    vectors++;
    if ({hit_count, miss_count} !== 32'h0) begin
      miscompares++; $display("FAIL reset_stats got %h/%h expected 0/0", hit_count, miss_count);
    end
`endif
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_clean_miss();
    logic [7:0] rdat;
    int stalls, wb0, fe0;
    wb0 = wb_total; fe0 = fe_total;
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, rdat, stalls);
    $display("read 14 -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (rdat !== 8'hAA) begin
      miscompares++; $display("FAIL miss14_data got %h expected AA", rdat);
    end
    vectors++;
    if (stalls !== LAT + 1) begin
      miscompares++; $display("FAIL miss14_stalls got %0d expected %0d", stalls, LAT + 1);
    end
    vectors++;
    if (wb_total - wb0 !== 0) begin
      miscompares++; $display("FAIL miss14_writeback got %0d cycles expected 0", wb_total - wb0);
    end
    vectors++;
    if (fe_total - fe0 !== LAT || fe_addr !== 6'h05) begin
      miscompares++; $display("FAIL miss14_fetch got %0d cycles addr %h expected %0d addr 05",
                              fe_total - fe0, fe_addr, LAT);
    end
  endtask

  task automatic test_read_hit();
    logic [7:0] rdat;
    int stalls;
    cpu_access(1'b1, 1'b0, 8'h15, 8'h00, rdat, stalls);
    $display("read 15 -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (rdat !== 8'hBB || stalls !== 0) begin
      miscompares++; $display("FAIL hit15 got %h stalls %0d expected BB stalls 0", rdat, stalls);
    end
  endtask

  task automatic test_dirty_evict();
    logic [7:0] rdat;
    int stalls, wb0, fe0;
    cpu_access(1'b0, 1'b1, 8'h16, 8'h5A, rdat, stalls);
    $display("write 16 <- 5A stalls %0d", stalls);
    vectors++;
    if (stalls !== 0) begin
      miscompares++; $display("FAIL write16_stalls got %0d expected 0", stalls);
    end
    cpu_access(1'b1, 1'b0, 8'h16, 8'h00, rdat, stalls);
    $display("read 16 -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (rdat !== 8'h5A || stalls !== 0) begin
      miscompares++; $display("FAIL read16 got %h stalls %0d expected 5A stalls 0", rdat, stalls);
    end
    wb0 = wb_total; fe0 = fe_total;
    cpu_access(1'b1, 1'b0, 8'h36, 8'h00, rdat, stalls);
    $display("read 36 -> %h stalls %0d wb %h/%h fetch %h", rdat, stalls, wb_addr, wb_data, fe_addr);
    vectors++;
    if (wb_total - wb0 !== LAT || wb_addr !== 6'h05) begin
      miscompares++; $display("FAIL evict_wb_addr got %0d cycles addr %h expected %0d addr 05",
                              wb_total - wb0, wb_addr, LAT);
    end
    vectors++;
    if (wb_data !== 32'hDD5ABBAA) begin
      miscompares++; $display("FAIL evict_wb_data got %h expected DD5ABBAA", wb_data);
    end
    vectors++;
    if (fe_total - fe0 !== LAT || fe_addr !== 6'h0D) begin
      miscompares++; $display("FAIL evict_fetch got %0d cycles addr %h expected %0d addr 0D",
                              fe_total - fe0, fe_addr, LAT);
    end
    vectors++;
    if (rdat !== 8'h33 || stalls !== 2 * LAT + 1) begin
      miscompares++; $display("FAIL evict_read got %h stalls %0d expected 33 stalls %0d",
                              rdat, stalls, 2 * LAT + 1);
    end
`ifdef DCACHE_STATS_EN
    vectors++;
    if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
      miscompares++; $display("FAIL stats got %0d/%0d expected 3/2", hit_count, miss_count);
    end
`endif
    // Freshly fetched line is clean: evicting it again needs no write-back.
    wb0 = wb_total;
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, rdat, stalls);
    $display("read 14 -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (rdat !== 8'hAA || stalls !== LAT + 1 || wb_total - wb0 !== 0) begin
      miscompares++; $display("FAIL clean_evict got %h stalls %0d wb %0d expected AA stalls %0d wb 0",
                              rdat, stalls, wb_total - wb0, LAT + 1);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] rdat;
    int stalls, guard, fe0;
    @(negedge clk);
    bus.read    = 1'b1;
    bus.address = 8'h20;
    guard = 0;
    while (!bus.mem_read && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 20) begin
      miscompares++; $display("FAIL abort_fetch_start got mem_read 0 expected 1 within 20 cycles");
    end
    rst      = 1'b1;
    bus.read = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0) begin
      miscompares++; $display("FAIL abort_strobe got mem_read %b busywait %b expected 0 0",
                              bus.mem_read, bus.busywait);
    end
`ifdef DCACHE_STATS_EN
    vectors++;
    if ({hit_count, miss_count} !== 32'h0) begin
      miscompares++; $display("FAIL abort_stats got %h/%h expected 0/0", hit_count, miss_count);
    end
`endif
    rst = 1'b0;
    fe0 = fe_total;
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, rdat, stalls);
    $display("post-reset read 14 -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (stalls !== LAT + 1 || fe_total - fe0 !== LAT || rdat !== 8'hAA) begin
      miscompares++; $display("FAIL reread14 got %h stalls %0d fetch %0d expected AA stalls %0d fetch %0d",
                              rdat, stalls, fe_total - fe0, LAT + 1, LAT);
    end
  endtask

  task automatic test_wrap_and_priority();
    logic [7:0] rdat;
    int stalls;
    cpu_access(1'b1, 1'b0, 8'hFF, 8'h00, rdat, stalls);
    $display("read FF -> %h stalls %0d fetch %h", rdat, stalls, fe_addr);
    vectors++;
    if (rdat !== 8'h88 || fe_addr !== 6'h3F || stalls !== LAT + 1) begin
      miscompares++; $display("FAIL wrap_ff got %h addr %h stalls %0d expected 88 addr 3F stalls %0d",
                              rdat, fe_addr, stalls, LAT + 1);
    end
    cpu_access(1'b1, 1'b1, 8'hFE, 8'h3C, rdat, stalls);
    cpu_access(1'b1, 1'b0, 8'hFE, 8'h00, rdat, stalls);
    $display("read FE -> %h stalls %0d", rdat, stalls);
    vectors++;
    if (rdat !== 8'h3C || stalls !== 0) begin
      miscompares++; $display("FAIL write_priority got %h stalls %0d expected 3C stalls 0", rdat, stalls);
    end
  endtask

  initial begin
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = 8'h00;
    bus.writedata = 8'h00;
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_dirty_evict();
    test_reset_mid_fetch();
    test_wrap_and_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
